// File: rtl/apb_cmd_master.sv
// apb_cmd_master: buffers write/read commands in a FIFO and issues each as a two-phase APB transfer.
//    clk        system clock, rising edge
//    rst        asynchronous reset, active-low
//    cmd_*      command stream in (valid/ready, direction, address, write data)
//    P*         APB initiator signals toward ECC_ENC_DEC (no PREADY, one-cycle ACCESS)
//    rsp_*      one-cycle read response strobe with captured data and address
//    busy       FIFO non-empty or transfer in progress
module apb_cmd_master #(
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int AMBA_WORD       = 32,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_write,
   input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [AMBA_WORD-1:0]       cmd_wdata,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   output logic [AMBA_WORD-1:0]       PWDATA,
   input  logic [AMBA_WORD-1:0]       PRDATA,
   output logic                       rsp_valid,
   output logic [AMBA_WORD-1:0]       rsp_rdata,
   output logic [AMBA_ADDR_WIDTH-1:0] rsp_addr,
   output logic                       busy
);
   localparam int PW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t                     state_q;
   logic [AMBA_ADDR_WIDTH-1:0] addr_mem_q [FIFO_DEPTH];
   logic [AMBA_WORD-1:0]       data_mem_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]      write_mem_q;
   logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]                count_q, count_d;
   logic                       full, empty, push, pop;
   logic                       psel_q, penable_q, pwrite_q, rsp_valid_q;
   logic [AMBA_ADDR_WIDTH-1:0] paddr_q, rsp_addr_q;
   logic [AMBA_WORD-1:0]       pwdata_q, rsp_rdata_q;

   assign full  = count_q == (PW+1)'(FIFO_DEPTH);
   assign empty = count_q == '0;
   assign push  = cmd_valid && !full;
   // A command is loaded whenever the bus is free for a new SETUP: from IDLE or straight after ACCESS
   assign pop   = !empty && state_q != SETUP;

   // Pointers wrap naturally because FIFO_DEPTH is a power of two
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
   end

   always_ff @(posedge clk)
      if (push) begin
         addr_mem_q[wr_ptr_q]  <= cmd_addr;
         data_mem_q[wr_ptr_q]  <= cmd_wdata;
         write_mem_q[wr_ptr_q] <= cmd_write;
      end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q     <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_addr_q  <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE, ACCESS: begin
               // Closing edge of a read ACCESS: PADDR is still the address of this transfer
               if (state_q == ACCESS && !pwrite_q) begin
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= PRDATA;
                  rsp_addr_q  <= paddr_q;
               end
               if (pop) begin
                  state_q   <= SETUP;
                  psel_q    <= 1'b1;
                  penable_q <= 1'b0;
                  pwrite_q  <= write_mem_q[rd_ptr_q];
                  paddr_q   <= addr_mem_q[rd_ptr_q];
                  // Reads leave the previous write data on PWDATA
                  if (write_mem_q[rd_ptr_q]) pwdata_q <= data_mem_q[rd_ptr_q];
               end else begin
                  state_q   <= IDLE;
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
               end
            end
            SETUP: begin
               state_q   <= ACCESS;
               penable_q <= 1'b1;
            end
            default: begin
               state_q   <= IDLE;
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
            end
         endcase
      end

   assign cmd_ready = !full;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_addr  = rsp_addr_q;
   assign busy      = !empty || state_q != IDLE;
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed bench for apb_cmd_master with an in-order transfer/response scoreboard.
module tb_apb_cmd_master;
   localparam int AW = 20;
   localparam int DW = 32;
   typedef struct {
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } xfer_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, busy;
   logic [AW-1:0] PADDR, rsp_addr;
   logic [DW-1:0] PWDATA, PRDATA, rsp_rdata;
   int            n_chk = 0;
   int            n_fail = 0;
   xfer_t         exp_x[$];
   logic [AW-1:0] exp_r[$];
   logic          last_rd = 1'b0;

   apb_cmd_master #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(DW), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] prd(input logic [AW-1:0] a);
      return (a == 20'h00010) ? 32'h1234_5678 : (32'hD00D_0000 | {12'h0, a});
   endfunction

   assign PRDATA = prd(PADDR);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cmd_valid = v;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
   endtask

   task automatic enq(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      xfer_t x;
      x.w = w;
      x.a = a;
      x.d = d;
      exp_x.push_back(x);
      if (!w) exp_r.push_back(a);
   endtask

   always @(negedge clk) begin : monitor
      xfer_t         xa;
      logic [AW-1:0] ra;
      if (!rst) last_rd <= 1'b0;
      else begin
         check("rsp_strobe", rsp_valid, last_rd);
         if (rsp_valid) begin
            if (exp_r.size() != 0) begin
               ra = exp_r.pop_front();
               check("rsp_addr", rsp_addr, ra);
               check("rsp_rdata", rsp_rdata, prd(ra));
            end else check("rsp_extra", exp_r.size(), 1);
         end
         if (PSEL && PENABLE) begin
            if (exp_x.size() != 0) begin
               xa = exp_x.pop_front();
               check("xfer_addr", PADDR, xa.a);
               check("xfer_dir", PWRITE, xa.w);
               if (xa.w) check("xfer_wdata", PWDATA, xa.d);
            end else check("xfer_extra", exp_x.size(), 1);
         end
         last_rd <= PSEL && PENABLE && !PWRITE;
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout n_chk=%0d", n_chk);
      $fatal(1);
   end

   initial begin
      int guard;
      #1 rst = 1'b0;
      #1;
      check("rst_psel", PSEL, 0);
      check("rst_pen", PENABLE, 0);
      check("rst_pwrite", PWRITE, 0);
      check("rst_rspv", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", cmd_ready, 1);
      check("rst_paddr", PADDR, 0);
      tick(); tick();
      rst = 1'b1;
      tick(); tick();
      check("idle_psel", PSEL, 0);
      check("idle_busy", busy, 0);
      check("idle_ready", cmd_ready, 1);

      // single write
      set_cmd(1, 1, 20'h00004, 32'hA5A5_0001);
      enq(1, 20'h00004, 32'hA5A5_0001);
      tick();
      set_cmd(0, 0, '0, '0);
      check("w0_psel", PSEL, 0);
      check("w0_busy", busy, 1);
      tick();
      check("w1_psel", PSEL, 1);
      check("w1_pen", PENABLE, 0);
      check("w1_pwrite", PWRITE, 1);
      check("w1_paddr", PADDR, 20'h00004);
      check("w1_pwdata", PWDATA, 32'hA5A5_0001);
      tick();
      check("w2_psel", PSEL, 1);
      check("w2_pen", PENABLE, 1);
      check("w2_paddr", PADDR, 20'h00004);
      tick();
      check("w3_psel", PSEL, 0);
      check("w3_pen", PENABLE, 0);
      check("w3_busy", busy, 0);
      check("w3_paddr_hold", PADDR, 20'h00004);
      tick();

      // single read
      set_cmd(1, 0, 20'h00010, 32'hFFFF_FFFF);
      enq(0, 20'h00010, '0);
      tick();
      set_cmd(0, 0, '0, '0);
      tick();
      check("r1_psel", PSEL, 1);
      check("r1_pen", PENABLE, 0);
      check("r1_pwrite", PWRITE, 0);
      check("r1_paddr", PADDR, 20'h00010);
      check("r1_pwdata_hold", PWDATA, 32'hA5A5_0001);
      tick();
      check("r2_pen", PENABLE, 1);
      tick();
      check("r3_rspv", rsp_valid, 1);
      check("r3_rdata", rsp_rdata, 32'h1234_5678);
      check("r3_raddr", rsp_addr, 20'h00010);
      check("r3_psel", PSEL, 0);
      tick();
      check("r4_rspv", rsp_valid, 0);
      check("r4_rdata_hold", rsp_rdata, 32'h1234_5678);

      // four back-to-back commands: W 0x0, W 0x4, W 0x8, R 0xC
      for (int k = 0; k < 10; k++) begin
         if (k < 4) begin
            set_cmd(1, k < 3, AW'(4 * k), 32'h1111_1111 * (k + 1));
            enq(k < 3, AW'(4 * k), 32'h1111_1111 * (k + 1));
         end else set_cmd(0, 0, '0, '0);
         tick();
         check($sformatf("b2b_psel_%0d", k), PSEL, (k >= 1 && k <= 8));
         check($sformatf("b2b_pen_%0d", k), PENABLE, (k >= 2 && k <= 8 && k % 2 == 0));
         if (k == 9) begin
            check("b2b_rspv", rsp_valid, 1);
            check("b2b_raddr", rsp_addr, 20'h0000C);
         end
      end
      tick(); tick();

      // continuous offer: FIFO fills after edge 6, offer at edge 7 is refused
      for (int k = 0; k < 8; k++) begin
         set_cmd(1, 1, AW'(32'h100 + 4 * k), 32'hF000_0000 + k);
         if (k < 7) enq(1, AW'(32'h100 + 4 * k), 32'hF000_0000 + k);
         tick();
         check($sformatf("full_ready_%0d", k), cmd_ready, k != 6);
      end
      set_cmd(0, 0, '0, '0);
      for (int j = 0; j < 20; j++) tick();
      check("full_drain_busy", busy, 0);
      check("full_left", exp_x.size(), 0);

      // ten reads through the FIFO, wrapping the pointers
      for (int i = 0; i < 10; i++) begin
         set_cmd(1, 0, AW'(4 * i), 32'h5555_5555);
         guard = 0;
         while (!cmd_ready && guard < 20) begin
            tick();
            guard++;
         end
         if (guard >= 20) check("wrap_ready_timeout", cmd_ready, 1);
         enq(0, AW'(4 * i), '0);
         tick();
      end
      set_cmd(0, 0, '0, '0);
      for (int j = 0; j < 30; j++) tick();
      check("wrap_busy", busy, 0);
      check("wrap_rsp_left", exp_r.size(), 0);
      check("wrap_xfer_left", exp_x.size(), 0);

      // reset asserted during a read ACCESS
      set_cmd(1, 0, 20'h00030, '0);
      tick();
      set_cmd(0, 0, '0, '0);
      tick();
      check("ra_setup_psel", PSEL, 1);
      tick();
      check("ra_access_pen", PENABLE, 1);
      #2 rst = 1'b0;
      #1;
      check("ra_psel", PSEL, 0);
      check("ra_pen", PENABLE, 0);
      check("ra_busy", busy, 0);
      check("ra_ready", cmd_ready, 1);
      check("ra_rspv", rsp_valid, 0);
      exp_x.delete();
      exp_r.delete();
      tick();
      rst = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         check("ra_after_rspv", rsp_valid, 0);
         check("ra_after_psel", PSEL, 0);
      end
      check("ra_after_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
